// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - one-hot op bit positions (bit0 = mul ... bit6 = modu)
//   - FSM state encoding
//   - helper to validate a one-hot op vector
package mdu_pkg;

    localparam int unsigned OP_W     = 7;
    localparam int unsigned OP_MUL   = 0;
    localparam int unsigned OP_MULH  = 1;
    localparam int unsigned OP_MULHU = 2;
    localparam int unsigned OP_DIV   = 3;
    localparam int unsigned OP_DIVU  = 4;
    localparam int unsigned OP_MOD   = 5;
    localparam int unsigned OP_MODU  = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    // True when exactly one bit is set.
    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - 7'd1)) == '0);
    endfunction

endpackage

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider on unsigned magnitudes.
//   clk, reset      : clock, synchronous active-high reset
//   start           : load dividend/divisor, clear partial remainder and counter
//   step            : perform one iteration (one quotient bit per cycle)
//   dividend/divisor: unsigned magnitudes sampled on start
//   quotient/remainder: current shift-register contents (final after WIDTH steps)
//   last            : high during the step that completes the WIDTH-th iteration
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;

    // Since rem < divisor < 2^WIDTH, bit WIDTH of the difference is a clean borrow.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        take    = ~diff[WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], take};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with valid/ready handshakes.
//   clk, reset          : clock, synchronous active-high reset
//   flush               : abandon any in-flight operation
//   in_valid/in_ready   : request handshake (op, src1, src2)
//   op                  : one-hot {modu,mod,divu,div,mulhu,mulh,mul}
//   out_valid/out_ready : result handshake; result held until accepted
// Mul ops take 2 cycles, divides WIDTH+2, divide-by-zero and bad ops 2.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    mdu_state_e state_q, state_d;

    logic             accept;
    logic             op_ok;
    logic             is_div_op;
    logic             is_sdiv;
    logic             s1_neg, s2_neg;
    logic [WIDTH-1:0] mag1, mag2;
    logic             div_start;
    logic             div_last;
    logic [WIDTH-1:0] quo_mag, rem_mag;

    logic [6:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               neg_quo_q, neg_rem_q, dz_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   quo_q, rem_q;

    logic               mul_signed;
    logic [2*WIDTH-1:0] a_ext, b_ext;

    // Request decode
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !flush;
        accept    = in_valid && in_ready;
        op_ok     = op_is_onehot(op);
        is_div_op = op_ok && (op[OP_DIV] | op[OP_DIVU] | op[OP_MOD] | op[OP_MODU]);
        is_sdiv   = op_ok && (op[OP_DIV] | op[OP_MOD]);
        s1_neg    = is_sdiv && src1[WIDTH-1];
        s2_neg    = is_sdiv && src2[WIDTH-1];
        mag1      = s1_neg ? -src1 : src1;
        mag2      = s2_neg ? -src2 : src2;
        div_start = accept && is_div_op && (src2 != '0);
    end

    // Next state; flush overrides everything except reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_div_op)        state_d = ST_MUL;
                    else if (src2 == '0)   state_d = ST_FIX;
                    else                   state_d = ST_DIV;
                end
            end
            ST_MUL:  state_d = ST_DONE;
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign out_valid = (state_q == ST_DONE);

    div_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .step      (state_q == ST_DIV),
        .dividend  (mag1),
        .divisor   (mag2),
        .quotient  (quo_mag),
        .remainder (rem_mag),
        .last      (div_last)
    );

    // Only mulh needs signed operands; mul's low half is sign-agnostic.
    always_comb begin
        mul_signed = op_q[OP_MULH];
        a_ext      = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
        b_ext      = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            prod_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            if (accept) begin
                // A non-one-hot op latches as all zeros so the AND-OR mux yields 0.
                op_q      <= op_ok ? op : '0;
                a_q       <= src1;
                b_q       <= src2;
                neg_quo_q <= s1_neg ^ s2_neg;
                neg_rem_q <= s1_neg;
                dz_q      <= (src2 == '0);
            end
            if (state_q == ST_MUL) begin
                prod_q <= a_ext * b_ext;
            end
            if (state_q == ST_FIX) begin
                quo_q <= dz_q ? '1  : (neg_quo_q ? -quo_mag : quo_mag);
                rem_q <= dz_q ? a_q : (neg_rem_q ? -rem_mag : rem_mag);
            end
        end
    end

    // AND-OR result select over the latched one-hot op
    always_comb begin
        result = ({WIDTH{op_q[OP_MUL]}}                   & prod_q[WIDTH-1:0])
               | ({WIDTH{op_q[OP_MULH] | op_q[OP_MULHU]}} & prod_q[2*WIDTH-1:WIDTH])
               | ({WIDTH{op_q[OP_DIV]  | op_q[OP_DIVU]}}  & quo_q)
               | ({WIDTH{op_q[OP_MOD]  | op_q[OP_MODU]}}  & rem_q);
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed bench for mul_div_unit (WIDTH=32 and WIDTH=16 builds).
// A cycle-level model of the 32-bit instance checks in_ready/out_valid/result every cycle.
module tb_mul_div_unit;

    localparam logic [6:0] MUL   = 7'h01;
    localparam logic [6:0] MULH  = 7'h02;
    localparam logic [6:0] MULHU = 7'h04;
    localparam logic [6:0] DIV   = 7'h08;
    localparam logic [6:0] DIVU  = 7'h10;
    localparam logic [6:0] MOD   = 7'h20;
    localparam logic [6:0] MODU  = 7'h40;

    logic        clk;
    int          cyc;
    int          tests;
    int          fails;

    // 32-bit instance
    logic        rst32, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]  op;
    logic [31:0] src1, src2, result;

    // 16-bit instance
    logic        r16, fl16, iv16, ir16, ov16, or16;
    logic [6:0]  op16;
    logic [15:0] a16, b16, res16;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (rst32),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    mul_div_unit #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .reset     (r16),
        .flush     (fl16),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .op        (op16),
        .src1      (a16),
        .src2      (b16),
        .out_valid (ov16),
        .out_ready (or16),
        .result    (res16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Architectural result of one op at WIDTH=32 plus its cycles-to-out_valid.
    function automatic void model(input logic [6:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        longint      sa, sb, q;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pu = {32'd0, a} * {32'd0, b};
        r = '0;
        lat = 2;
        if ($countones(o) != 1) begin
            r = '0;
        end else if (o == MUL) begin
            r = pu[31:0];
        end else if (o == MULH) begin
            q = sa * sb;
            r = q[63:32];
        end else if (o == MULHU) begin
            r = pu[63:32];
        end else begin
            if (b != 0) lat = 34;
            if (o == DIV) begin
                if (b == 0) r = '1; else begin q = sa / sb; r = q[31:0]; end
            end else if (o == MOD) begin
                if (b == 0) r = a; else begin q = sa % sb; r = q[31:0]; end
            end else if (o == DIVU) begin
                r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            end else begin
                r = (b == 0) ? a : a % b;
            end
        end
    endfunction

    // Cycle-level reference for the 32-bit instance.
    bit          m_busy;
    int          m_due;
    logic [31:0] m_res;

    always @(negedge clk) begin
        bit          exp_ov;
        logic [31:0] r;
        int          lat;
        if (rst32) begin
            m_busy = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !flush});
            exp_ov = m_busy && (cyc >= m_due);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            if (exp_ov) chk("model result", result, m_res);
            if (flush) begin
                m_busy = 1'b0;
            end else if (!m_busy && in_valid) begin
                model(op, src1, src2, r, lat);
                m_busy = 1'b1;
                m_due  = cyc + lat;
                m_res  = r;
            end else if (exp_ov && out_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic run_op(input string nm, input logic [6:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit stall);
        bit got;
        int t0;
        @(posedge clk); #1;
        op = o; src1 = a; src2 = b; in_valid = 1'b1; out_ready = !stall;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        chk({nm, " accept"}, {31'd0, got}, 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 7'($urandom); src1 = $urandom; src2 = $urandom;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({nm, " latency"}, got ? 32'(cyc - t0) : 32'hDEAD_BEEF, 32'(lat));
        chk({nm, " result"}, result, exp);
        if (stall) begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                chk({nm, " held valid"}, {31'd0, out_valid}, 32'd1);
                chk({nm, " held result"}, result, exp);
                chk({nm, " held in_ready"}, {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk({nm, " ready after handshake"}, {31'd0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic run16(input string nm, input logic [6:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input int lat);
        bit got;
        int t0;
        @(posedge clk); #1;
        op16 = o; a16 = a; b16 = b; iv16 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ir16) got = 1'b1;
        end
        chk({nm, " accept"}, {31'd0, got}, 32'd1);
        t0 = cyc;
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ov16) got = 1'b1;
        end
        chk({nm, " latency"}, got ? 32'(cyc - t0) : 32'hDEAD_BEEF, 32'(lat));
        chk({nm, " result"}, {16'd0, res16}, {16'd0, exp});
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] ra, rb, rexp;
        int          rlat;
        int          cnt, t0;
        bit          got;
        cyc = 0; tests = 0; fails = 0;
        rst32 = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src1 = '0; src2 = '0;
        r16 = 1'b1; fl16 = 1'b0; iv16 = 1'b0; or16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1 rst32 = 1'b0; r16 = 1'b0;
        @(negedge clk);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst result", result, 32'd0);
        chk("rst16 out_valid", {31'd0, ov16}, 32'd0);
        chk("rst16 result", {16'd0, res16}, 32'd0);

        // Multiply family
        run_op("mul",   MUL,   32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 2, 1'b0);
        run_op("mulh",  MULH,  32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("mulhu", MULHU, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0002, 2, 1'b0);
        // Divide family
        run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("mod",   MOD,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
        run_op("divu",  DIVU,  32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34, 1'b0);
        run_op("mod+-", MOD,   32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);
        // Divide by zero and signed overflow
        run_op("divu0", DIVU,  32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("modu0", MODU,  32'd5, 32'd0, 32'd5, 2, 1'b0);
        run_op("div0",  DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 2, 1'b0);
        run_op("divov", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
        run_op("modov", MOD,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
        // Non-one-hot op
        run_op("badop", 7'h03, 32'd9, 32'd9, 32'd0, 2, 1'b0);
        run_op("zeroop", 7'h00, 32'd9, 32'd9, 32'd0, 2, 1'b0);
        // Result held under backpressure
        run_op("stall", MULHU, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0002, 2, 1'b1);

        // Flush in DIV iteration 10
        @(posedge clk); #1;
        op = DIVU; src1 = 32'd1000; src2 = 32'd3; in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        chk("flush accept", {31'd0, got}, 32'd1);
        t0 = cyc;
        @(posedge clk); #1 in_valid = 1'b0;
        while (cyc < t0 + 10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("flush no out_valid", 32'(cnt), 32'd0);
        run_op("post-flush mul", MUL, 32'd7, 32'd6, 32'd42, 2, 1'b0);

        // A few more vectors against the model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = (i == 2) ? 32'd0 : ($urandom >> (i * 4));
            model(7'(1 << (i + 1)), ra, rb, rexp, rlat);
            run_op("vec", 7'(1 << (i + 1)), ra, rb, rexp, rlat, 1'b0);
        end

        // WIDTH=16 build
        run16("div16", DIV, 16'd100, 16'd7, 16'd14, 18);
        run16("mod16", MOD, 16'd100, 16'd7, 16'd2, 18);
        @(posedge clk); #1;
        op16 = DIVU; a16 = 16'd1000; b16 = 16'd3; iv16 = 1'b1;
        @(negedge clk);
        chk("rst16 accept", {31'd0, ir16}, 32'd1);
        @(posedge clk); #1 iv16 = 1'b0;
        repeat (5) @(posedge clk);
        #1 r16 = 1'b1;
        @(posedge clk); #1 r16 = 1'b0;
        @(negedge clk);
        chk("midrst16 out_valid", {31'd0, ov16}, 32'd0);
        chk("midrst16 in_ready", {31'd0, ir16}, 32'd1);
        chk("midrst16 result", {16'd0, res16}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ov16) cnt++;
        end
        chk("midrst16 no out_valid", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
